spi_cfg_seq: RTL
================

Name: spi_cfg_seq

Overview:
Table-driven SPI configuration sequencer for the ADC/DAC/PLL converters, built as the parametrised successor to the fixed read–write–poll bring-up FSM. It fetches step words from a synchronous table (ROM or register bank) and executes WRITE, POLL_EQ, POLL_GT and END steps through the existing 8-bit-style SPI master command/ack interface. Polls are bounded by a retry limit and a retry gap. The block reports done, error, the failing step index and the last read value.

Parameters:
AW, 7, SPI register address width
DW, 8, SPI data width
IDX_W, 5, step index width
NUM_STEPS, 32, table depth; index NUM_STEPS acts as implicit END
POLL_MAX, 16, poll attempts before error; 0 = unlimited
POLL_GAP, 1000, idle clk cycles between poll attempts (>=1)
AUTO_START, 1, 1 = run the sequence once after reset release without start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; (re)runs the sequence from step 0 when not busy
step_idx  out  IDX_W  table address
step_word  in  2+AW+2*DW  {op[1:0], addr, data, mask}; valid one clk after step_idx changes
cmd_write  out  1  SPI write request
cmd_write_ack  in  1  SPI write complete
write_addr  out  AW  SPI write address
write_data  out  DW  SPI write data
cmd_read  out  1  SPI read request
cmd_read_ack  in  1  SPI read complete; read_data valid this cycle
read_addr  out  AW  SPI read address
read_data  in  DW  SPI read data
busy  out  1  sequence in progress
done  out  1  level; sequence finished without error
error  out  1  level; poll limit exhausted (or verify mismatch)
err_step  out  IDX_W  step index that failed
last_rd  out  DW  last read_data captured on cmd_read_ack

Behaviour:
- Reset values: all outputs 0; state IDLE; step_idx 0; retry counter 0.
- Opcodes: 0 WRITE; 1 POLL_EQ (pass when (read_data & mask) == (data & mask)); 2 POLL_GT (pass when (read_data & mask) > data, unsigned); 3 END.
- States: IDLE, FETCH, DECODE, WR_REQ, RD_REQ, EVAL, GAP, DONE, ERR.
- IDLE: go to FETCH when start is high, or in the first cycle after reset release if AUTO_START=1. Clear done, error and err_step; set step_idx=0 and busy=1.
- FETCH: wait one cycle for table latency. DECODE: register the step word and dispatch on op. END, or step_idx==NUM_STEPS, goes to DONE.
- WR_REQ: cmd_write=1 with write_addr/write_data held stable until cmd_write_ack is sampled high. Drop cmd_write on the next cycle, increment step_idx, go to FETCH.
- RD_REQ: cmd_read=1 with read_addr held until cmd_read_ack. Capture read_data into last_rd in the ack cycle; go to EVAL.
- EVAL: on pass, clear the retry counter, increment step_idx, go to FETCH. On fail, increment the retry counter.
  - If POLL_MAX!=0 and retries==POLL_MAX: go to ERR and set err_step=step_idx.
  - Otherwise go to GAP.
- GAP: count POLL_GAP cycles, then go to RD_REQ (same step).
- Request/ack rules:
  - Never assert cmd_read and cmd_write together.
  - An ack with no request pending is ignored.
  - An ack in the same cycle a request rises is accepted.
- DONE: done=1, busy=0. ERR: error=1, busy=0. Both states hold until start, which re-enters the FETCH path as from IDLE. start while busy is ignored.
- Retry counter: width clog2(POLL_MAX+1), minimum 1. It saturates when POLL_MAX=0 (unlimited polling).
- Reset mid-operation: return to IDLE immediately and drop any request. The SPI master is reset by the same rst_n.

Optional Feature:
SEQ_WRITE_VERIFY_EN:
- Defined: after each WRITE ack, read back the same address and compare (read_data & mask) against (data & mask). Mismatch → ERR with err_step = that step. Match → next step. The read-back does not consume poll retries.
- Undefined: WRITE completes on ack alone; no read-back is issued.

Test Plan:
- AUTO_START=1; table {WRITE 0x18=0x00, END}; model acks after 5 cycles → one cmd_write with addr 0x18, data 0x00; done=1, busy=0, error=0.
- Table {POLL_EQ 0x18 data 0x07 mask 0xFF, END}; reads return 0x03, 0x03, 0x07 → exactly 3 cmd_read pulses spaced ≥POLL_GAP cycles; last_rd=0x07; done=1.
- POLL_MAX=4; POLL_GT 0x19 data 0x02; reads always return 0x01 → exactly 4 reads; error=1, err_step=0, done=0.
- POLL_GT with mask 0x0F, data 0x02; read returns 0xF1 → fail (0x1 ≤ 2); then 0x03 → pass; step advances.
- Pulse start at step 1 while busy → ignored. After done, pulse start → step_idx returns to 0, sequence repeats, done clears then re-asserts.
- rst_n low while cmd_read is high → cmd_read, busy and done all 0 asynchronously. On release with AUTO_START=1, the sequence restarts at step 0.

Source files
------------

// File: rtl/spi_cfg_seq.sv
// Table-driven SPI configuration sequencer: fetches {op, addr, data, mask} steps and runs WRITE/POLL/END
// through the SPI master command/ack handshake. Optional write read-back verify: SEQ_WRITE_VERIFY_EN.
module spi_cfg_seq #(
    parameter int AW         = 7,
    parameter int DW         = 8,
    parameter int IDX_W      = 5,
    parameter int NUM_STEPS  = 32,
    parameter int POLL_MAX   = 16,
    parameter int POLL_GAP   = 1000,
    parameter int AUTO_START = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [IDX_W-1:0]        step_idx,
    input  logic [2+AW+2*DW-1:0]    step_word,
    output logic                    cmd_write,
    input  logic                    cmd_write_ack,
    output logic [AW-1:0]           write_addr,
    output logic [DW-1:0]           write_data,
    output logic                    cmd_read,
    input  logic                    cmd_read_ack,
    output logic [AW-1:0]           read_addr,
    input  logic [DW-1:0]           read_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [IDX_W-1:0]        err_step,
    output logic [DW-1:0]           last_rd
);

    localparam int SW = 2 + AW + 2 * DW;
    // Index needs one extra code so that NUM_STEPS itself can act as an implicit END.
    localparam int IW = ($clog2(NUM_STEPS + 1) > IDX_W) ? $clog2(NUM_STEPS + 1) : IDX_W;
    localparam int RW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_POLL_EQ = 2'd1;
    localparam logic [1:0] OP_POLL_GT = 2'd2;
    localparam logic [1:0] OP_END     = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR_REQ,
        S_RD_REQ,
        S_EVAL,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx_q;
    logic [RW-1:0]   retry_q;
    logic [GW-1:0]   gap_q;
    logic            auto_pend;

    logic [1:0]      op_q;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   mask_q;

    logic [1:0]      f_op;
    logic [AW-1:0]   f_addr;
    logic [DW-1:0]   f_data;
    logic [DW-1:0]   f_mask;

    logic [DW-1:0]   masked;
    logic            pass;
    logic            launch;
    logic [RW-1:0]   retry_nx;
    logic            retry_lim;

    // With POLL_MAX=0 polling is unlimited, so the counter must hold at all-ones instead of wrapping.
    function automatic logic [RW-1:0] retry_inc(input logic [RW-1:0] r);
        if (POLL_MAX == 0 && r == {RW{1'b1}})
            return r;
        return r + RW'(1);
    endfunction

    assign f_op   = step_word[SW-1 -: 2];
    assign f_addr = step_word[2*DW +: AW];
    assign f_data = step_word[DW +: DW];
    assign f_mask = step_word[0 +: DW];

    assign step_idx  = idx_q[IDX_W-1:0];
    assign retry_nx  = retry_inc(retry_q);
    assign retry_lim = (POLL_MAX != 0) && (retry_nx == RW'(POLL_MAX));

    assign launch = ((state == S_IDLE) && (start || auto_pend)) ||
                    (((state == S_DONE) || (state == S_ERR)) && start);

    always_comb begin
        masked = last_rd & mask_q;
        pass   = 1'b0;
        case (op_q)
            OP_POLL_GT: pass = (masked > data_q);
            default:    pass = (masked == (data_q & mask_q));
        endcase
    end

    // Step fields are datapath only; they are always written in DECODE before EVAL reads them.
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            op_q   <= f_op;
            data_q <= f_data;
            mask_q <= f_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            auto_pend  <= (AUTO_START != 0);
            cmd_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            cmd_read   <= 1'b0;
            read_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_step   <= '0;
            last_rd    <= '0;
        end else if (launch) begin
            auto_pend <= 1'b0;
            idx_q     <= '0;
            retry_q   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_step  <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    state <= state;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (idx_q == IW'(NUM_STEPS) || f_op == OP_END) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (f_op == OP_WRITE) begin
                        cmd_write  <= 1'b1;
                        write_addr <= f_addr;
                        write_data <= f_data;
                        state      <= S_WR_REQ;
                    end else begin
                        cmd_read  <= 1'b1;
                        read_addr <= f_addr;
                        state     <= S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (cmd_write_ack) begin
                        cmd_write <= 1'b0;
`ifdef SEQ_WRITE_VERIFY_EN
                        cmd_read  <= 1'b1;
                        read_addr <= write_addr;
                        state     <= S_RD_REQ;
`else
                        idx_q     <= idx_q + IW'(1);
                        state     <= S_FETCH;
`endif
                    end
                end
                S_RD_REQ: begin
                    if (cmd_read_ack) begin
                        cmd_read <= 1'b0;
                        last_rd  <= read_data;
                        state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (pass) begin
                        retry_q <= '0;
                        idx_q   <= idx_q + IW'(1);
                        state   <= S_FETCH;
                    end else if (op_q == OP_WRITE) begin
                        // Read-back mismatch fails at once and leaves the poll retry budget alone.
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        err_step <= idx_q[IDX_W-1:0];
                        state    <= S_ERR;
                    end else begin
                        retry_q <= retry_nx;
                        if (retry_lim) begin
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            err_step <= idx_q[IDX_W-1:0];
                            state    <= S_ERR;
                        end else begin
                            gap_q <= '0;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(POLL_GAP - 1)) begin
                        cmd_read <= 1'b1;
                        state    <= S_RD_REQ;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
